axi_stream_strip_header: RTL

AXI_STREAM_STRIP_HEADER -- requirements
Module: axi_stream_strip_header

---
 rtl/axi_stream_pkg.sv | 14 +
 rtl/axi_stream_strip_header_skid_buffer.sv | 61 ++++++
 rtl/axi_stream_strip_header.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/axi_stream_pkg.sv
// Shared AXI-Stream widths and the header-strip FSM state encoding.
package axi_stream_pkg;

  localparam int AXIS_DATA_WD      = 32;
  localparam int AXIS_DATA_BYTE_WD = AXIS_DATA_WD / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_STREAM = 2'd2,
    ST_FLUSH  = 2'd3
  } strip_state_e;

endpackage

// File: rtl/axi_stream_strip_header_skid_buffer.sv
// Two-entry skid buffer: registered output, registered upstream ready.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  assign s_ready = !skid_valid_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

  // Refill the output slot from the skid entry first, else from upstream;
  // park an upstream beat in the skid entry while the output is stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (m_ready || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = s_valid;
        if (s_valid) out_data_d = s_data;
      end
    end else if (s_valid && s_ready) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips N = byte_strip_cnt+1 leading bytes from each packet and realigns
// the remaining payload so it starts at the MSB byte of the first beat.
module axi_stream_strip_header
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = AXIS_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic                    valid_strip,
  output logic                    ready_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  output logic                    err_short
);

  // One extra bit so a strip of a full beat (N = DATA_BYTE_WD) is representable.
  localparam int              SW     = BYTE_CNT_WD + 1;
  localparam logic [SW-1:0]   NBYTES = SW'(DATA_BYTE_WD);
  localparam int              PW     = DATA_WD + DATA_BYTE_WD + 1;

  strip_state_e              state_q, state_d;
  logic [SW-1:0]             n_q, n_d;
  logic [DATA_WD-1:0]        res_data_q, res_data_d;
  logic [DATA_BYTE_WD-1:0]   res_keep_q, res_keep_d;
  logic                      err_q, err_d;

  logic                      sb_valid, sb_ready, sb_last;
  logic [DATA_WD-1:0]        sb_data;
  logic [DATA_BYTE_WD-1:0]   sb_keep;
  logic [PW-1:0]             sb_out;

  // Left shift keeps the tail of this beat for the next output; right shift
  // fills the current output with the head of this beat. A shift by the full
  // beat width produces zero, so N = DATA_BYTE_WD passes beats unshifted.
  logic [SW-1:0]             rsh;
  logic [DATA_WD-1:0]        new_res_data, merge_data;
  logic [DATA_BYTE_WD-1:0]   new_res_keep, merge_keep;

  assign rsh          = NBYTES - n_q;
  assign new_res_data = data_in << {n_q, 3'b000};
  assign new_res_keep = keep_in << n_q;
  assign merge_data   = res_data_q | (data_in >> {rsh, 3'b000});
  assign merge_keep   = res_keep_q | (keep_in >> rsh);

  assign err_short = err_q;

  // Next-state, handshake and residual update for the strip FSM.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    res_data_d  = res_data_q;
    res_keep_d  = res_keep_q;
    err_d       = 1'b0;
    ready_strip = 1'b0;
    ready_in    = 1'b0;
    sb_valid    = 1'b0;
    sb_data     = merge_data;
    sb_keep     = merge_keep;
    sb_last     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_strip = 1'b1;
        if (valid_strip) begin
          n_d     = {1'b0, byte_strip_cnt} + SW'(1);
          state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        ready_in = 1'b1;
        if (valid_in) begin
          res_data_d = new_res_data;
          res_keep_d = new_res_keep;
          if (!last_in)          state_d = ST_STREAM;
          else if (|new_res_keep) state_d = ST_FLUSH;
          else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_STREAM: begin
        ready_in = sb_ready;
        sb_valid = valid_in;
        sb_last  = last_in && !(|new_res_keep);
        if (valid_in && sb_ready) begin
          res_data_d = new_res_data;
          res_keep_d = new_res_keep;
          if (last_in) state_d = (|new_res_keep) ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        sb_valid = 1'b1;
        sb_data  = res_data_q;
        sb_keep  = res_keep_q;
        sb_last  = 1'b1;
        if (sb_ready) begin
          res_data_d = '0;
          res_keep_d = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, strip count, residual and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      res_data_q <= '0;
      res_keep_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      res_data_q <= res_data_d;
      res_keep_q <= res_keep_d;
      err_q      <= err_d;
    end
  end

  skid_buffer #(.WIDTH(PW)) u_out (
    .clk     (clk),
    .rst     (rst),
    .s_valid (sb_valid),
    .s_ready (sb_ready),
    .s_data  ({sb_last, sb_keep, sb_data}),
    .m_valid (valid_out),
    .m_ready (ready_out),
    .m_data  (sb_out)
  );

  assign {last_out, keep_out, data_out} = sb_out;

endmodule
